// File: rtl/a2d_arb_pkg.sv
// Shared types and constants for the A2D converter arbiter.
package a2d_arb_pkg;

    localparam int unsigned CH_W        = 3;
    localparam int unsigned RES_W       = 12;
    localparam int unsigned TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr_i+1.
module rr_pick #(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     win_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        cand  = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
        win_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D_intf converter among NUM_REQ requesters,
// with a blanking cycle after start and a watchdog on missing completions.
module a2d_arbiter
    import a2d_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [CH_W*NUM_REQ-1:0]   req_chnnl,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [NUM_REQ-1:0]        rsp_err,
    output logic [RES_W-1:0]          rsp_res,
    output logic [CH_W-1:0]           chnnl,
    output logic                      strt_cnv,
    input  logic                      cnv_cmplt,
    input  logic [RES_W-1:0]          res
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   vld_q, vld_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [RES_W-1:0]     res_q, res_d;
    logic [CH_W-1:0]      chnnl_q, chnnl_d;
    logic                 strt_q, strt_d;

    logic [NUM_REQ-1:0]   pick_win;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // ptr_q holds the last winner; NUM_REQ-1 after reset so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            idx_q   <= '0;
            timer_q <= '0;
            gnt_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            res_q   <= '0;
            chnnl_q <= '0;
            strt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            res_q   <= res_d;
            chnnl_q <= chnnl_d;
            strt_q  <= strt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        gnt_d   = gnt_q;
        vld_d   = '0;
        err_d   = '0;
        res_d   = res_q;
        chnnl_d = chnnl_q;
        strt_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    chnnl_d = req_chnnl[32'(pick_idx) * CH_W +: CH_W];
                    gnt_d   = pick_win;
                    strt_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // timer_q == 0 is the blanking cycle: a completion seen there is stale
                if ((timer_q != '0) && cnv_cmplt) begin
                    res_d   = res;
                    vld_d   = gnt_q;
                    state_d = DONE;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 2)) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = idx_q;
                    state_d = IDLE;
                end
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt      = gnt_q;
    assign rsp_vld  = vld_q;
    assign rsp_err  = err_q;
    assign rsp_res  = res_q;
    assign chnnl    = chnnl_q;
    assign strt_cnv = strt_q;

endmodule
